rename_stage: RTL and testbench

Parametrised register-rename stage for the out-of-order 6502 core. It renames a group of up to WIDTH micro-ops per cycle against a speculative RAT, allocates destinations from a physical free list, and tracks per-physical-register ready bits. Unlike the fixed 4-wide renamer, it also:
- maintains a committed (retirement) RAT;
- recovers the full rename state in one cycle on `flush`;
- exposes the free-register count.

It sits between the micro-op sequencer and the ROB/issue queues.

---
 rtl/rename_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_rename_stage.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// Register-rename stage: renames up to WIDTH micro-ops per cycle against a speculative RAT,
// allocates from a physical free list, tracks ready bits and restores from the committed RAT on flush.
module rename_stage #(
  parameter int WIDTH     = 4,
  parameter int ARCH_REGS = 10,
  parameter int PHYS_REGS = 32,
  parameter int AR_W      = 4,
  parameter int PR_W      = 5,
  parameter int CMPLT_W   = 5,
  parameter int RETIRE_W  = 6,
  localparam int FC_W     = $clog2(PHYS_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_slot_valid,
  input  logic [WIDTH-1:0]         in_dst_en,
  input  logic [WIDTH*AR_W-1:0]    in_dst,
  input  logic [WIDTH*AR_W-1:0]    in_src0,
  input  logic [WIDTH*AR_W-1:0]    in_src1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_slot_valid,
  output logic [WIDTH*PR_W-1:0]    out_dst_phys,
  output logic [WIDTH*PR_W-1:0]    out_old_phys,
  output logic [WIDTH*PR_W-1:0]    out_src0_phys,
  output logic [WIDTH*PR_W-1:0]    out_src1_phys,
  output logic [2*WIDTH-1:0]       out_src_ready,
  input  logic [CMPLT_W-1:0]       cmplt_valid,
  input  logic [CMPLT_W*PR_W-1:0]  cmplt_phys,
  input  logic [RETIRE_W-1:0]      ret_valid,
  input  logic [RETIRE_W*AR_W-1:0] ret_arch,
  input  logic [RETIRE_W*PR_W-1:0] ret_phys,
  input  logic [RETIRE_W*PR_W-1:0] ret_old_phys,
  output logic [FC_W-1:0]          free_count
);

  localparam logic [AR_W-1:0]      LP_ARCH_LIM = AR_W'(ARCH_REGS);
  localparam logic [PHYS_REGS-1:0] LP_CONST    = PHYS_REGS'(3);

  logic [PR_W-1:0]         r_spec_rat [ARCH_REGS];
  logic [PR_W-1:0]         r_com_rat  [ARCH_REGS];
  logic [PHYS_REGS-1:0]    r_free;
  logic [PHYS_REGS-1:0]    r_ready;
  logic [FC_W-1:0]         r_free_count;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_out_slot_valid;
  logic [WIDTH*PR_W-1:0]   r_out_dst;
  logic [WIDTH*PR_W-1:0]   r_out_old;
  logic [WIDTH*PR_W-1:0]   r_out_src0;
  logic [WIDTH*PR_W-1:0]   r_out_src1;
  logic [2*WIDTH-1:0]      r_out_src_rdy;

  logic [PR_W-1:0]         w_rat     [ARCH_REGS];
  logic [PR_W-1:0]         w_com_nxt [ARCH_REGS];
  logic [ARCH_REGS-1:0]    w_prod;
  logic [PHYS_REGS-1:0]    w_alloc;
  logic [PHYS_REGS-1:0]    w_cmplt_hit;
  logic [PHYS_REGS-1:0]    w_freed;
  logic [PHYS_REGS-1:0]    w_mapped;
  logic [PHYS_REGS-1:0]    w_free_nxt;
  logic [PHYS_REGS-1:0]    w_ready_nxt;
  logic [FC_W-1:0]         w_need;
  logic [FC_W-1:0]         w_fc_nxt;
  logic [WIDTH*PR_W-1:0]   w_dst;
  logic [WIDTH*PR_W-1:0]   w_old;
  logic [WIDTH*PR_W-1:0]   w_src0;
  logic [WIDTH*PR_W-1:0]   w_src1;
  logic [2*WIDTH-1:0]      w_src_rdy;
  logic [AR_W-1:0]         w_a_src0;
  logic [AR_W-1:0]         w_a_src1;
  logic [AR_W-1:0]         w_a_dst;
  logic [PR_W-1:0]         w_new;
  logic                    w_found;
  logic                    w_accept;

  function automatic logic [FC_W-1:0] popcnt(input logic [PHYS_REGS-1:0] v);
    logic [FC_W-1:0] c = '0;
    for (int k = 0; k < PHYS_REGS; k++) c = c + FC_W'(v[k]);
    return c;
  endfunction

  always_comb begin
    w_cmplt_hit = '0;
    for (int c = 0; c < CMPLT_W; c++)
      if (cmplt_valid[c]) w_cmplt_hit[cmplt_phys[c*PR_W +: PR_W]] = 1'b1;
  end

  // NOTE: blocking assignments here so each slot sees the RAT and free-list updates of earlier slots.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    w_rat     = r_spec_rat;
    w_prod    = '0;
    w_alloc   = '0;
    w_need    = '0;
    w_dst     = '0;
    w_old     = '0;
    w_src0    = '0;
    w_src1    = '0;
    w_src_rdy = '0;
    w_a_src0  = '0;
    w_a_src1  = '0;
    w_a_dst   = '0;
    w_new     = '0;
    w_found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_a_src0 = in_src0[i*AR_W +: AR_W];
      w_a_src1 = in_src1[i*AR_W +: AR_W];
      w_a_dst  = in_dst[i*AR_W +: AR_W];
      // Out-of-range sources read the constant phys 0, always ready.
      if (w_a_src0 < LP_ARCH_LIM) begin
        w_src0[i*PR_W +: PR_W] = w_rat[w_a_src0];
        w_src_rdy[2*i] = !w_prod[w_a_src0] &&
                         (r_ready[w_rat[w_a_src0]] || w_cmplt_hit[w_rat[w_a_src0]]);
      end else begin
        w_src_rdy[2*i] = 1'b1;
      end
      if (w_a_src1 < LP_ARCH_LIM) begin
        w_src1[i*PR_W +: PR_W] = w_rat[w_a_src1];
        w_src_rdy[2*i+1] = !w_prod[w_a_src1] &&
                           (r_ready[w_rat[w_a_src1]] || w_cmplt_hit[w_rat[w_a_src1]]);
      end else begin
        w_src_rdy[2*i+1] = 1'b1;
      end
      if (in_slot_valid[i] && in_dst_en[i] && (w_a_dst < LP_ARCH_LIM)) begin
        w_need  = w_need + FC_W'(1);
        w_found = 1'b0;
        w_new   = '0;
        for (int p = 2; p < PHYS_REGS; p++) begin
          if (!w_found && r_free[p] && !w_alloc[p]) begin
            w_new   = PR_W'(p);
            w_found = 1'b1;
          end
        end
        if (w_found) w_alloc[w_new] = 1'b1;
        w_old[i*PR_W +: PR_W] = w_rat[w_a_dst];
        w_dst[i*PR_W +: PR_W] = w_new;
        w_rat[w_a_dst]        = w_new;
        w_prod[w_a_dst]       = 1'b1;
      end
    end
  end

  assign in_ready = !flush && (!r_out_valid || out_ready) && (r_free_count >= w_need);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_com_nxt = r_com_rat;
    w_freed   = '0;
    w_mapped  = '0;
    for (int r = 0; r < RETIRE_W; r++) begin
      if (ret_valid[r] && (ret_arch[r*AR_W +: AR_W] < LP_ARCH_LIM))
        w_com_nxt[ret_arch[r*AR_W +: AR_W]] = ret_phys[r*PR_W +: PR_W];
      if (ret_valid[r] && (ret_old_phys[r*PR_W +: PR_W] >= PR_W'(2)))
        w_freed[ret_old_phys[r*PR_W +: PR_W]] = 1'b1;
    end
    for (int a = 0; a < ARCH_REGS; a++) w_mapped[w_com_nxt[a]] = 1'b1;
    // Flush rebuilds both vectors from the committed map; completions that cycle are dropped.
    if (flush) begin
      w_free_nxt  = ~w_mapped & ~LP_CONST;
      w_ready_nxt = r_ready | w_mapped | LP_CONST;
    end else begin
      w_free_nxt  = (r_free & ~(w_accept ? w_alloc : '0)) | w_freed;
      w_ready_nxt = ((r_ready | w_cmplt_hit) & ~(w_accept ? w_alloc : '0)) | LP_CONST;
    end
    w_fc_nxt = popcnt(w_free_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the RATs are small flop arrays, not RAM, so they take an explicit reset value.
      for (int a = 0; a < ARCH_REGS; a++) begin
        r_spec_rat[a] <= PR_W'(a + 2);
        r_com_rat[a]  <= PR_W'(a + 2);
      end
      for (int p = 0; p < PHYS_REGS; p++) r_free[p] <= (p >= ARCH_REGS + 2);
      r_ready          <= '1;
      r_free_count     <= FC_W'(PHYS_REGS - ARCH_REGS - 2);
      r_out_valid      <= 1'b0;
      r_out_slot_valid <= '0;
      r_out_dst        <= '0;
      r_out_old        <= '0;
      r_out_src0       <= '0;
      r_out_src1       <= '0;
      r_out_src_rdy    <= '0;
    end else begin
      r_com_rat    <= w_com_nxt;
      r_free       <= w_free_nxt;
      r_ready      <= w_ready_nxt;
      r_free_count <= w_fc_nxt;
      if (flush) begin
        r_spec_rat  <= w_com_nxt;
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_spec_rat       <= w_rat;
        r_out_valid      <= 1'b1;
        r_out_slot_valid <= in_slot_valid;
        r_out_dst        <= w_dst;
        r_out_old        <= w_old;
        r_out_src0       <= w_src0;
        r_out_src1       <= w_src1;
        r_out_src_rdy    <= w_src_rdy;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_slot_valid = r_out_slot_valid;
  assign out_dst_phys   = r_out_dst;
  assign out_old_phys   = r_out_old;
  assign out_src0_phys  = r_out_src0;
  assign out_src1_phys  = r_out_src1;
  assign out_src_ready  = r_out_src_rdy;
  assign free_count     = r_free_count;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios with hand-derived values, then randomized
// traffic compared against an array/queue-based reference model of the renaming rules.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  in_slot_valid, in_dst_en;
  logic [15:0] in_dst, in_src0, in_src1;
  logic        in_ready, out_valid;
  logic [3:0]  out_slot_valid;
  logic [19:0] out_dst_phys, out_old_phys, out_src0_phys, out_src1_phys;
  logic [7:0]  out_src_ready;
  logic [4:0]  cmplt_valid;
  logic [24:0] cmplt_phys;
  logic [5:0]  ret_valid;
  logic [23:0] ret_arch;
  logic [29:0] ret_phys, ret_old_phys;
  logic [5:0]  free_count;

  int n_cmp = 0;
  int n_bad = 0;

  rename_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_dst_en(in_dst_en), .in_dst(in_dst),
    .in_src0(in_src0), .in_src1(in_src1), .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_valid(out_slot_valid), .out_dst_phys(out_dst_phys), .out_old_phys(out_old_phys),
    .out_src0_phys(out_src0_phys), .out_src1_phys(out_src1_phys), .out_src_ready(out_src_ready),
    .cmplt_valid(cmplt_valid), .cmplt_phys(cmplt_phys), .ret_valid(ret_valid),
    .ret_arch(ret_arch), .ret_phys(ret_phys), .ret_old_phys(ret_old_phys),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { int arch; int phys; int old; } ren_t;
  int   m_spec[10], m_com[10];
  bit   m_free[32], m_ready[32];
  bit   m_ov;
  bit   m_sv[4], m_r0[4], m_r1[4], m_wr[4];
  int   m_dst[4], m_old[4], m_s0[4], m_s1[4], m_nd[4], m_ad[4];
  ren_t m_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush = 0; in_valid = 0; out_ready = 1;
    in_slot_valid = '0; in_dst_en = '0; in_dst = '0; in_src0 = '0; in_src1 = '0;
    cmplt_valid = '0; cmplt_phys = '0;
    ret_valid = '0; ret_arch = '0; ret_phys = '0; ret_old_phys = '0;
  endtask

  task automatic set_slot(input int i, input bit v, input bit de, input int d, input int s0, input int s1);
    in_slot_valid[i] = v;
    in_dst_en[i] = de;
    in_dst[i*4 +: 4] = 4'(d);
    in_src0[i*4 +: 4] = 4'(s0);
    in_src1[i*4 +: 4] = 4'(s1);
  endtask

  task automatic set_ret(input int r, input int a, input int p, input int o);
    ret_valid[r] = 1'b1;
    ret_arch[r*4 +: 4] = 4'(a);
    ret_phys[r*5 +: 5] = 5'(p);
    ret_old_phys[r*5 +: 5] = 5'(o);
  endtask

  task automatic set_cmplt(input int c, input int p);
    cmplt_valid[c] = 1'b1;
    cmplt_phys[c*5 +: 5] = 5'(p);
  endtask

  function automatic int g_dst(input int i);  return int'(out_dst_phys[i*5 +: 5]);  endfunction
  function automatic int g_old(input int i);  return int'(out_old_phys[i*5 +: 5]);  endfunction
  function automatic int g_s0(input int i);   return int'(out_src0_phys[i*5 +: 5]); endfunction
  function automatic int g_s1(input int i);   return int'(out_src1_phys[i*5 +: 5]); endfunction

  task automatic do_reset();
    clear_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int a = 0; a < 10; a++) begin m_spec[a] = a + 2; m_com[a] = a + 2; end
    for (int p = 0; p < 32; p++) begin m_free[p] = (p >= 12); m_ready[p] = 1; end
    m_ov = 0;
    for (int i = 0; i < 4; i++) begin
      m_sv[i] = 0; m_r0[i] = 0; m_r1[i] = 0;
      m_dst[i] = 0; m_old[i] = 0; m_s0[i] = 0; m_s1[i] = 0;
    end
    m_q.delete();
  endtask

  function automatic int count_free();
    int n = 0;
    for (int p = 0; p < 32; p++) n += int'(m_free[p]);
    return n;
  endfunction

  function automatic bit model_in_ready();
    int need = 0;
    for (int i = 0; i < 4; i++)
      if (in_slot_valid[i] && in_dst_en[i] && in_dst[i*4 +: 4] < 4'd10) need++;
    return !flush && (!m_ov || out_ready) && (count_free() >= need);
  endfunction

  // Newest mapping of arch a as seen by slot i: latest earlier writer in the group, else the RAT.
  function automatic void find_map(input int i, input int a, output int p, output bit in_grp);
    in_grp = 0;
    p = m_spec[a];
    for (int k = i - 1; k >= 0; k--)
      if (!in_grp && m_wr[k] && m_ad[k] == a) begin p = m_nd[k]; in_grp = 1; end
  endfunction

  task automatic model_step();
    bit   acc, g;
    bit   cm[32], mapped[32];
    int   fl[$];
    int   a, p;
    acc = in_valid && model_in_ready();
    for (int k = 0; k < 32; k++) begin cm[k] = 0; mapped[k] = 0; end
    for (int c = 0; c < 5; c++) if (cmplt_valid[c]) cm[int'(cmplt_phys[c*5 +: 5])] = 1;
    for (int i = 0; i < 4; i++) m_wr[i] = 0;
    if (acc) begin
      for (int k = 2; k < 32; k++) if (m_free[k]) fl.push_back(k);
      for (int i = 0; i < 4; i++) begin
        a = int'(in_src0[i*4 +: 4]);
        if (a >= 10) begin m_s0[i] = 0; m_r0[i] = 1; end
        else begin find_map(i, a, p, g); m_s0[i] = p; m_r0[i] = !g && (m_ready[p] || cm[p]); end
        a = int'(in_src1[i*4 +: 4]);
        if (a >= 10) begin m_s1[i] = 0; m_r1[i] = 1; end
        else begin find_map(i, a, p, g); m_s1[i] = p; m_r1[i] = !g && (m_ready[p] || cm[p]); end
        a = int'(in_dst[i*4 +: 4]);
        m_sv[i] = in_slot_valid[i];
        if (in_slot_valid[i] && in_dst_en[i] && a < 10) begin
          find_map(i, a, p, g);
          m_old[i] = p;
          m_nd[i] = fl.pop_front();
          m_dst[i] = m_nd[i];
          m_ad[i] = a;
          m_wr[i] = 1;
        end else begin
          m_dst[i] = 0;
          m_old[i] = 0;
        end
      end
      for (int i = 0; i < 4; i++) if (m_wr[i]) m_free[m_nd[i]] = 0;
    end
    for (int r = 0; r < 6; r++) begin
      if (ret_valid[r]) begin
        if (ret_arch[r*4 +: 4] < 4'd10) m_com[int'(ret_arch[r*4 +: 4])] = int'(ret_phys[r*5 +: 5]);
        if (ret_old_phys[r*5 +: 5] >= 5'd2) m_free[int'(ret_old_phys[r*5 +: 5])] = 1;
      end
    end
    if (flush) begin
      for (int x = 0; x < 10; x++) begin m_spec[x] = m_com[x]; mapped[m_com[x]] = 1; end
      for (int k = 0; k < 32; k++) begin
        m_free[k] = (k >= 2) && !mapped[k];
        if (mapped[k]) m_ready[k] = 1;
      end
      m_ov = 0;
      m_q.delete();
    end else begin
      for (int k = 2; k < 32; k++) if (cm[k]) m_ready[k] = 1;
      for (int i = 0; i < 4; i++) begin
        if (m_wr[i]) begin
          m_ready[m_nd[i]] = 0;
          m_spec[m_ad[i]] = m_nd[i];
          m_q.push_back('{arch: m_ad[i], phys: m_nd[i], old: m_old[i]});
        end
      end
      if (acc) m_ov = 1;
      else if (out_ready) m_ov = 0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (free_count !== 6'd20) begin n_bad++; $display("FAIL reset_free_count: got %0d want 20", free_count); end
    n_cmp++; if ({out_dst_phys, out_old_phys, out_src0_phys, out_src1_phys, out_src_ready, out_slot_valid} !== '0) begin
      n_bad++; $display("FAIL reset_out_buses: got dst=%h old=%h want all 0", out_dst_phys, out_old_phys);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_first_group();
    do_reset();
    set_slot(0, 1, 1, 0, 1, 1);
    set_slot(1, 1, 1, 0, 0, 0);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (g_dst(0) != 12 || g_old(0) != 2 || g_s0(0) != 3 || out_src_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL first_slot0: got dst=%0d old=%0d src0=%0d rdy=%b want 12 2 3 1", g_dst(0), g_old(0), g_s0(0), out_src_ready[0]);
    end
    n_cmp++; if (g_dst(1) != 13 || g_old(1) != 12 || g_s0(1) != 12 || out_src_ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL first_slot1: got dst=%0d old=%0d src0=%0d rdy=%b want 13 12 12 0", g_dst(1), g_old(1), g_s0(1), out_src_ready[2]);
    end
    n_cmp++; if (free_count !== 6'd18) begin n_bad++; $display("FAIL first_free_count: got %0d want 18", free_count); end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) set_slot(i, (g < 4 || i < 3), 1, i, 0, 0);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    n_cmp++; if (free_count !== 6'd1) begin n_bad++; $display("FAIL starve_drain: got %0d want 1", free_count); end
    set_slot(0, 1, 1, 4, 0, 0);
    set_slot(1, 1, 1, 5, 0, 0);
    set_slot(2, 0, 0, 0, 0, 0);
    set_slot(3, 0, 0, 0, 0, 0);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL starve_blocked: got %b want 0", in_ready); end
    tick();
    set_ret(0, 3, 15, 5);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL starve_same_cycle_free: got %b want 0", in_ready); end
    tick();
    ret_valid = '0;
    #1;
    n_cmp++; if (free_count !== 6'd2) begin n_bad++; $display("FAIL starve_freed_count: got %0d want 2", free_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL starve_accept: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (g_dst(0) != 5 || g_dst(1) != 31 || free_count !== 6'd0) begin
      n_bad++; $display("FAIL starve_alloc: got dst0=%0d dst1=%0d fc=%0d want 5 31 0", g_dst(0), g_dst(1), free_count);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    set_slot(0, 1, 1, 0, 0, 0);
    in_valid = 1;
    tick();
    set_slot(0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (g_s0(0) != 12 || out_src_ready[0] !== 1'b0) begin
      n_bad++; $display("FAIL bypass_pending: got src0=%0d rdy=%b want 12 0", g_s0(0), out_src_ready[0]);
    end
    set_cmplt(2, 12);
    tick();
    cmplt_valid = '0;
    n_cmp++; if (g_s0(0) != 12 || out_src_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL bypass_hit: got src0=%0d rdy=%b want 12 1", g_s0(0), out_src_ready[0]);
    end
    tick();
    in_valid = 0;
    n_cmp++; if (out_src_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bypass_sticky: got %b want 1", out_src_ready[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      set_slot(0, 1, 1, 0, 0, 0);
      set_slot(1, 1, 1, 1, 0, 0);
      in_valid = 1;
      tick();
    end
    flush = 1;
    set_ret(0, 0, 12, 2);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 0;
    ret_valid = '0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (free_count !== 6'd20) begin n_bad++; $display("FAIL flush_free_count: got %0d want 20", free_count); end
    set_slot(0, 1, 0, 0, 0, 1);
    set_slot(1, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_resume: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (g_s0(0) != 12 || g_s1(0) != 3 || out_src_ready[1:0] !== 2'b11) begin
      n_bad++; $display("FAIL flush_recovered: got src0=%0d src1=%0d rdy=%b want 12 3 11", g_s0(0), g_s1(0), out_src_ready[1:0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    set_slot(0, 1, 1, 2, 5, 0);
    in_valid = 1;
    tick();
    set_slot(0, 1, 1, 2, 2, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || g_dst(0) != 12 || g_old(0) != 4 || g_s0(0) != 7 || g_s1(0) != 2) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b dst=%0d old=%0d s0=%0d s1=%0d want 1 12 4 7 2", k, out_valid, g_dst(0), g_old(0), g_s0(0), g_s1(0));
      end
      tick();
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || g_dst(0) != 13 || g_old(0) != 12 || g_s0(0) != 12 || out_src_ready[0] !== 1'b0) begin
      n_bad++; $display("FAIL bp_next: got v=%b dst=%0d old=%0d s0=%0d rdy=%b want 1 13 12 12 0", out_valid, g_dst(0), g_old(0), g_s0(0), out_src_ready[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 0;
    set_slot(0, 1, 1, 1, 0, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_pre: got %b want 1", out_valid); end
    rst = 1;
    tick();
    rst = 0;
    out_ready = 1;
    n_cmp++; if (out_valid !== 1'b0 || free_count !== 6'd20 || out_dst_phys !== '0 || out_src_ready !== '0) begin
      n_bad++; $display("FAIL mrst_state: got v=%b fc=%0d dst=%h rdy=%h want 0 20 0 0", out_valid, free_count, out_dst_phys, out_src_ready);
    end
    set_slot(0, 1, 1, 1, 1, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (g_dst(0) != 12 || g_old(0) != 3 || g_s0(0) != 3) begin
      n_bad++; $display("FAIL mrst_rat: got dst=%0d old=%0d s0=%0d want 12 3 3", g_dst(0), g_old(0), g_s0(0));
    end
  endtask

  // ---------------- randomized traffic ----------------
  task automatic gen_stim();
    int   nr, p;
    ren_t e;
    clear_in();
    in_valid  = ($urandom % 10) < 7;
    out_ready = ($urandom % 4) != 0;
    flush     = ($urandom % 32) == 0;
    for (int i = 0; i < 4; i++)
      set_slot(i, ($urandom % 5) != 0, ($urandom % 10) < 7, $urandom % 12, $urandom % 12, $urandom % 12);
    for (int c = 0; c < 5; c++) begin
      p = $urandom % 32;
      if (($urandom % 5) < 2 && !m_free[p]) set_cmplt(c, p);
    end
    nr = (($urandom % 3) == 0) ? 0 : $urandom_range(0, 6);
    for (int r = 0; r < nr; r++) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        set_ret(r, e.arch, e.phys, e.old);
      end
    end
  endtask

  task automatic test_random();
    logic [22:0] got, exp;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen_stim();
      #1;
      n_cmp++; if (in_ready !== model_in_ready()) begin
        n_bad++; $display("FAIL rnd_in_ready @%0d: got %b want %b", cyc, in_ready, model_in_ready());
      end
      model_step();
      tick();
      n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL rnd_out_valid @%0d: got %b want %b", cyc, out_valid, m_ov); end
      n_cmp++; if (int'(free_count) != count_free()) begin
        n_bad++; $display("FAIL rnd_free_count @%0d: got %0d want %0d", cyc, free_count, count_free());
      end
      for (int i = 0; i < 4; i++) begin
        got = {out_slot_valid[i], out_dst_phys[i*5 +: 5], out_old_phys[i*5 +: 5],
               out_src0_phys[i*5 +: 5], out_src1_phys[i*5 +: 5], out_src_ready[2*i +: 2]};
        exp = {m_sv[i], 5'(m_dst[i]), 5'(m_old[i]), 5'(m_s0[i]), 5'(m_s1[i]), m_r1[i], m_r0[i]};
        n_cmp++; if (got !== exp) begin
          n_bad++; $display("FAIL rnd_slot%0d @%0d: got %h want %h", i, cyc, got, exp);
        end
      end
    end
    clear_in();
  endtask

  initial begin
    rst = 1;
    clear_in();
    test_reset();
    test_first_group();
    test_starvation();
    test_bypass();
    test_flush();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
